sap_obi_safe_reg_demux: RTL and testbench
=========================================

Name: sap_obi_safe_reg_demux

Overview:
- 1-master-to-2-slave OBI demux placed between each SAP core data port and the rest of the system.
- Port 0 forwards to the internal system crossbar. Port 1 forwards to the safe CPU register block.
- Requests inside [ADDR_START, ADDR_END) go to port 1; all other addresses go to port 0.
- Tracks outstanding transactions, blocks port switching while responses are pending, and returns responses in order.

Parameters:
- MAX_OUTSTANDING, 2: maximum granted-but-unanswered transactions; range 1..15.
- ADDR_START, 32'h20000000: inclusive start of the safe register window.
- ADDR_END, 32'h20000100: exclusive end of the safe register window.
- TIMEOUT_CYCLES, 256: response watchdog limit; used only with SAP_DEMUX_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- m_req_i, m_we_i  in  1  master request, write enable
- m_addr_i, m_wdata_i  in  32  master address, write data
- m_be_i  in  4  master byte enables
- m_gnt_o, m_rvalid_o  out  1  grant and response valid to master
- m_rdata_o  out  32  response data to master
- s_req_o  out  2  per-port request; bit0 = xbar, bit1 = safe reg
- s_addr_o, s_wdata_o  out  32  broadcast to both ports
- s_we_o  out  1  broadcast to both ports
- s_be_o  out  4  broadcast to both ports
- s_gnt_i, s_rvalid_i  in  2  per-port grant and response valid
- s_rdata0_i, s_rdata1_i  in  32  per-port response data
- spurious_rvalid_o  out  1  1-cycle pulse: unexpected response seen
- timeout_o  out  1  sticky watchdog flag

Behaviour:
- Decode (combinational): sel = (m_addr_i >= ADDR_START) && (m_addr_i < ADDR_END).
- State registers:
  - cnt: width $clog2(MAX_OUTSTANDING+1).
  - act_sel: 1 bit, the port that owns the outstanding transactions.
- allow = (cnt == 0) || ((sel == act_sel) && (cnt < MAX_OUTSTANDING)).
  - allow uses registered cnt only; there is no combinational path from s_rvalid_i to s_req_o.
- Request path:
  - s_req_o[sel] = m_req_i & allow; the other bit is 0.
  - m_gnt_o = allow & s_gnt_i[sel].
  - The grant is combinational, so request-to-grant adds 0 cycles.
- Handshake (hs) = m_req_i & m_gnt_o.
  - On hs: act_sel <= sel.
- Response (rsp) = s_rvalid_i[act_sel] & (cnt != 0).
  - m_rvalid_o = rsp; m_rdata_o = act_sel ? s_rdata1_i : s_rdata0_i.
  - m_rdata_o is only meaningful while m_rvalid_o = 1.
- Counter update:
  - hs only: cnt+1. rsp only: cnt-1. Both in the same cycle: unchanged. Neither: unchanged.
- Switching ports: a request to the other port stalls (gnt = 0, no s_req) until cnt reaches 0. In the cycle cnt reads 0 it is forwarded.
- Full: at cnt == MAX_OUTSTANDING all requests stall, even if a response arrives that cycle. Forwarding resumes the following cycle.
- Spurious response: any s_rvalid_i bit with cnt == 0, or s_rvalid_i[~act_sel] = 1.
  - spurious_rvalid_o pulses for 1 cycle.
  - The response is dropped: not forwarded, cnt unchanged.
- Counter never wraps. Reaching MAX_OUTSTANDING+1 or going below 0 is impossible by construction (full stall, rsp gated by cnt != 0).
- Reset: cnt = 0, act_sel = 0, spurious_rvalid_o = 0, timeout_o = 0.
  - While rst_i = 1: s_req_o = 0, m_gnt_o = 0, m_rvalid_o = 0.
  - Reset mid-transaction discards all pending state. Responses arriving after reset are spurious.

Optional Feature:
- Macro: SAP_DEMUX_TIMEOUT_EN.
- Enabled:
  - A wait counter increments each cycle with cnt != 0 and no rsp; it clears on rsp or when cnt == 0.
  - When the wait counter reaches TIMEOUT_CYCLES: timeout_o sets (sticky until rst_i) and cnt is forced to 0 next cycle.
  - Later responses from that port report as spurious.
- Disabled: no wait counter; timeout_o is tied to 0.

Test Plan:
- Read to 32'h19020000 with s_gnt_i = 2'b01, then s_rvalid_i[0] with rdata 32'hCAFE0001 -> s_req_o = 2'b01; m_gnt_o same cycle; m_rvalid_o = 1 with m_rdata_o = 32'hCAFE0001; cnt returns to 0.
- Boundary decode, one access each to 32'h1FFFFFFC, 32'h20000000, 32'h200000FC, 32'h20000100 -> s_req_o = 2'b01, 2'b10, 2'b10, 2'b01.
- Two back-to-back grants to port 0, no responses, third request -> m_gnt_o = 0 at cnt = 2. Respond once -> third request granted the cycle after the response.
- Port 0 outstanding (cnt = 1), request to 32'h20000010 -> stalled until port 0 rvalid; s_req_o = 2'b10 in the cycle cnt reads 0.
- s_rvalid_i = 2'b10 with cnt = 0; and hs plus rsp in the same cycle at cnt = 1 -> spurious_rvalid_o pulses once; m_rvalid_o stays 0; cnt stays 1 after the simultaneous event.
- With SAP_DEMUX_TIMEOUT_EN and TIMEOUT_CYCLES = 8: grant 1 read, no response -> timeout_o = 1 after 8 cycles; cnt = 0; a late rvalid pulses spurious_rvalid_o. Without the macro, timeout_o stays 0.

Source files
------------

// File: rtl/sap_obi_safe_reg_demux.sv
// OBI 1-to-2 demux: port 0 = system crossbar, port 1 = safe CPU register window.
// Optional response watchdog enabled by defining SAP_DEMUX_TIMEOUT_EN.
module sap_obi_safe_reg_demux #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] ADDR_START      = 32'h2000_0000,
  parameter logic [31:0] ADDR_END        = 32'h2000_0100,
  parameter int unsigned TIMEOUT_CYCLES  = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m_req_i,
  input  logic        m_we_i,
  input  logic [31:0] m_addr_i,
  input  logic [31:0] m_wdata_i,
  input  logic [3:0]  m_be_i,
  output logic        m_gnt_o,
  output logic        m_rvalid_o,
  output logic [31:0] m_rdata_o,
  output logic [1:0]  s_req_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_wdata_o,
  output logic        s_we_o,
  output logic [3:0]  s_be_o,
  input  logic [1:0]  s_gnt_i,
  input  logic [1:0]  s_rvalid_i,
  input  logic [31:0] s_rdata0_i,
  input  logic [31:0] s_rdata1_i,
  output logic        spurious_rvalid_o,
  output logic        timeout_o
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          act_sel_q, act_sel_d;
  logic          spurious_q, spurious_d;
  logic          sel, allow, hs, rsp, expire;

  assign sel = (m_addr_i >= ADDR_START) && (m_addr_i < ADDR_END);

  // Only the registered count gates the request; no rvalid-to-req path exists.
  assign allow = !rst_i &&
                 ((cnt_q == '0) || ((sel == act_sel_q) && (cnt_q < MAX_CNT)));

  always_comb begin
    s_req_o = 2'b00;
    if (m_req_i && allow) begin
      s_req_o = sel ? 2'b10 : 2'b01;
    end
  end

  assign m_gnt_o    = allow & s_gnt_i[sel];
  assign hs         = m_req_i & m_gnt_o;
  assign rsp        = !rst_i && s_rvalid_i[act_sel_q] && (cnt_q != '0);
  assign m_rvalid_o = rsp;
  assign m_rdata_o  = act_sel_q ? s_rdata1_i : s_rdata0_i;

  assign s_addr_o  = m_addr_i;
  assign s_wdata_o = m_wdata_i;
  assign s_we_o    = m_we_i;
  assign s_be_o    = m_be_i;

  always_comb begin
    act_sel_d  = hs ? sel : act_sel_q;
    spurious_d = ((s_rvalid_i != 2'b00) && (cnt_q == '0)) || s_rvalid_i[~act_sel_q];
    cnt_d      = cnt_q;
    if (hs && !rsp) begin
      cnt_d = cnt_q + 1'b1;
    end else if (rsp && !hs) begin
      cnt_d = cnt_q - 1'b1;
    end
    if (expire) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      act_sel_q  <= 1'b0;
      spurious_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      act_sel_q  <= act_sel_d;
      spurious_q <= spurious_d;
    end
  end

  assign spurious_rvalid_o = spurious_q;

`ifdef SAP_DEMUX_TIMEOUT_EN
  localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] TO_LIM = WW'(TIMEOUT_CYCLES);

  logic [WW-1:0] wait_q, wait_d;
  logic          timeout_q, timeout_d;

  // Expiry abandons the pending transactions; their late responses become spurious.
  always_comb begin
    wait_d = wait_q + 1'b1;
    expire = 1'b0;
    if ((cnt_q == '0) || rsp) begin
      wait_d = '0;
    end else if (wait_d == TO_LIM) begin
      expire = 1'b1;
      wait_d = '0;
    end
    timeout_d = timeout_q | expire;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign expire    = 1'b0;
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_sap_obi_safe_reg_demux.sv
// Directed self-checking bench for sap_obi_safe_reg_demux (MAX_OUTSTANDING=2, TIMEOUT_CYCLES=8).
module tb_sap_obi_safe_reg_demux;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        m_req_i, m_we_i;
  logic [31:0] m_addr_i, m_wdata_i;
  logic [3:0]  m_be_i;
  logic        m_gnt_o, m_rvalid_o;
  logic [31:0] m_rdata_o;
  logic [1:0]  s_req_o;
  logic [31:0] s_addr_o, s_wdata_o;
  logic        s_we_o;
  logic [3:0]  s_be_o;
  logic [1:0]  s_gnt_i, s_rvalid_i;
  logic [31:0] s_rdata0_i, s_rdata1_i;
  logic        spurious_rvalid_o, timeout_o;

  int n_cmp = 0;
  int n_err = 0;

  sap_obi_safe_reg_demux #(
    .MAX_OUTSTANDING(2),
    .ADDR_START(32'h2000_0000),
    .ADDR_END(32'h2000_0100),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m_req_i(m_req_i), .m_we_i(m_we_i), .m_addr_i(m_addr_i),
    .m_wdata_i(m_wdata_i), .m_be_i(m_be_i),
    .m_gnt_o(m_gnt_o), .m_rvalid_o(m_rvalid_o), .m_rdata_o(m_rdata_o),
    .s_req_o(s_req_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
    .s_we_o(s_we_o), .s_be_o(s_be_o),
    .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i),
    .s_rdata0_i(s_rdata0_i), .s_rdata1_i(s_rdata1_i),
    .spurious_rvalid_o(spurious_rvalid_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    m_req_i = 1'b0; m_we_i = 1'b0; m_addr_i = '0; m_wdata_i = '0; m_be_i = '0;
    s_gnt_i = 2'b00; s_rvalid_i = 2'b00;
  endtask

  task automatic req(input logic [31:0] addr, input logic [1:0] gnt);
    m_req_i = 1'b1; m_addr_i = addr; m_be_i = 4'hF; s_gnt_i = gnt;
  endtask

  logic [31:0] bnd_addr [4];
  logic [1:0]  bnd_req  [4];

  initial begin
    bnd_addr[0] = 32'h1FFF_FFFC; bnd_req[0] = 2'b01;
    bnd_addr[1] = 32'h2000_0000; bnd_req[1] = 2'b10;
    bnd_addr[2] = 32'h2000_00FC; bnd_req[2] = 2'b10;
    bnd_addr[3] = 32'h2000_0100; bnd_req[3] = 2'b01;
    s_rdata0_i = 32'hCAFE_0001;
    s_rdata1_i = 32'h5AFE_0002;

    // Reset with every input active
    rst_i = 1'b1;
    req(32'h0000_0000, 2'b11);
    s_rvalid_i = 2'b11;
    #1;
    chk("rst_s_req", 32'(s_req_o), 32'h0);
    chk("rst_gnt", 32'(m_gnt_o), 32'h0);
    chk("rst_rvalid", 32'(m_rvalid_o), 32'h0);
    step(); step();
    rst_i = 1'b0;
    idle();
    step();
    chk("rst_spurious", 32'(spurious_rvalid_o), 32'h0);
    chk("rst_timeout", 32'(timeout_o), 32'h0);

    // Basic read on port 0
    req(32'h1902_0000, 2'b01);
    #1;
    chk("rd0_s_req", 32'(s_req_o), 32'h1);
    chk("rd0_gnt", 32'(m_gnt_o), 32'h1);
    step();
    idle();
    s_rvalid_i = 2'b01;
    #1;
    chk("rd0_rvalid", 32'(m_rvalid_o), 32'h1);
    chk("rd0_rdata", m_rdata_o, 32'hCAFE_0001);
    step();
    idle();
    // cnt back to 0: port 1 is granted at once
    req(32'h2000_0040, 2'b10);
    #1;
    chk("rd1_s_req", 32'(s_req_o), 32'h2);
    chk("rd1_gnt", 32'(m_gnt_o), 32'h1);
    step();
    idle();
    s_rvalid_i = 2'b10;
    #1;
    chk("rd1_rvalid", 32'(m_rvalid_o), 32'h1);
    chk("rd1_rdata", m_rdata_o, 32'h5AFE_0002);
    step();
    idle();

    // Boundary decode, no grant so nothing becomes outstanding
    for (int i = 0; i < 4; i++) begin
      req(bnd_addr[i], 2'b00);
      #1;
      chk($sformatf("bnd%0d_s_req", i), 32'(s_req_o), 32'(bnd_req[i]));
      step();
    end
    idle();
    step();

    // Fill to MAX_OUTSTANDING, then stall even with a same-cycle response
    req(32'h0000_0100, 2'b01);
    #1; chk("full_gnt_a", 32'(m_gnt_o), 32'h1);
    step();
    #1; chk("full_gnt_b", 32'(m_gnt_o), 32'h1);
    step();
    #1;
    chk("full_gnt_c", 32'(m_gnt_o), 32'h0);
    chk("full_s_req", 32'(s_req_o), 32'h0);
    s_rvalid_i = 2'b01;
    #1;
    chk("full_gnt_rsp", 32'(m_gnt_o), 32'h0);
    chk("full_rvalid", 32'(m_rvalid_o), 32'h1);
    step();
    s_rvalid_i = 2'b00;
    #1;
    chk("full_gnt_after", 32'(m_gnt_o), 32'h1);
    step();
    idle();
    s_rvalid_i = 2'b01;
    step(); step();
    idle();
    #1;
    chk("full_drained_spur", 32'(spurious_rvalid_o), 32'h0);

    // Port switch stalls until port 0 drains
    req(32'h0000_0200, 2'b01);
    step();
    req(32'h2000_0010, 2'b11);
    #1;
    chk("sw_s_req_a", 32'(s_req_o), 32'h0);
    chk("sw_gnt_a", 32'(m_gnt_o), 32'h0);
    step();
    #1; chk("sw_s_req_b", 32'(s_req_o), 32'h0);
    s_rvalid_i = 2'b01;
    #1;
    chk("sw_s_req_rsp", 32'(s_req_o), 32'h0);
    chk("sw_rvalid", 32'(m_rvalid_o), 32'h1);
    step();
    s_rvalid_i = 2'b00;
    #1;
    chk("sw_s_req_fwd", 32'(s_req_o), 32'h2);
    chk("sw_gnt_fwd", 32'(m_gnt_o), 32'h1);
    step();
    idle();
    s_rvalid_i = 2'b10;
    #1; chk("sw_rvalid1", 32'(m_rvalid_o), 32'h1);
    step();
    idle();
    step();

    // Spurious at cnt == 0
    s_rvalid_i = 2'b10;
    #1; chk("sp0_rvalid", 32'(m_rvalid_o), 32'h0);
    step();
    s_rvalid_i = 2'b00;
    #1; chk("sp0_pulse", 32'(spurious_rvalid_o), 32'h1);
    step();
    chk("sp0_clear", 32'(spurious_rvalid_o), 32'h0);

    // Handshake and response together at cnt == 1 keep cnt at 1
    req(32'h0000_0300, 2'b01);
    step();
    s_rvalid_i = 2'b01;
    #1;
    chk("sim_gnt", 32'(m_gnt_o), 32'h1);
    chk("sim_rvalid", 32'(m_rvalid_o), 32'h1);
    step();
    s_rvalid_i = 2'b00;
    #1; chk("sim_gnt_cnt1", 32'(m_gnt_o), 32'h1);
    step();
    #1; chk("sim_gnt_full", 32'(m_gnt_o), 32'h0);
    idle();
    s_rvalid_i = 2'b10;
    #1; chk("sp1_rvalid", 32'(m_rvalid_o), 32'h0);
    step();
    s_rvalid_i = 2'b00;
    #1; chk("sp1_pulse", 32'(spurious_rvalid_o), 32'h1);
    s_rvalid_i = 2'b01;
    step(); step();
    idle();
    #1; chk("sp1_drained", 32'(spurious_rvalid_o), 32'h0);

    // Watchdog: one read with no response
    req(32'h0000_0400, 2'b01);
    step();
    idle();
    for (int i = 0; i < 7; i++) step();
    chk("to_before", 32'(timeout_o), 32'h0);
    step();
`ifdef SAP_DEMUX_TIMEOUT_EN
    chk("to_set", 32'(timeout_o), 32'h1);
    s_rvalid_i = 2'b01;
    #1; chk("to_late_rvalid", 32'(m_rvalid_o), 32'h0);
    step();
    s_rvalid_i = 2'b00;
    #1; chk("to_late_spur", 32'(spurious_rvalid_o), 32'h1);
    step();
    chk("to_sticky", 32'(timeout_o), 32'h1);
`else
    chk("to_off", 32'(timeout_o), 32'h0);
    s_rvalid_i = 2'b01;
    #1; chk("to_off_rvalid", 32'(m_rvalid_o), 32'h1);
    step();
    s_rvalid_i = 2'b00;
    #1; chk("to_off_spur", 32'(spurious_rvalid_o), 32'h0);
    step();
    chk("to_off_still", 32'(timeout_o), 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
